// File: rtl/img_pingpong_loader.sv
// rtl/img_pingpong_loader.sv - UART byte stream to ping-pong image RAM loader with inference handshake
module img_pingpong_loader #(
    parameter int          PIX_W       = 8,
    parameter int          IMG_PIXELS  = 784,
    parameter int          ADDR_W      = 10,
    parameter logic [7:0]  HDR0        = 8'h55,
    parameter logic [7:0]  HDR1        = 8'hAA,
    parameter logic [23:0] TIMEOUT_CYC = 24'd2400000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              mode,
    input  logic              arm,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              net_start,
    output logic              net_bank,
    input  logic              net_done,
    output logic              disp_bank,
    output logic              busy,
    output logic [7:0]        drop_cnt,
    output logic [7:0]        err_cnt
);

    typedef enum logic [1:0] {
        S_HUNT = 2'd0,
        S_HDR  = 2'd1,
        S_LOAD = 2'd2,
        S_FULL = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_PIXELS - 1);
    localparam logic [23:0]       IDLE_LAST = TIMEOUT_CYC - 24'd1;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [23:0]         r_idle;
    logic                r_armed;
    logic                r_seen_hdr0;
    logic                r_wr_en;
    logic                r_wr_bank;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [PIX_W-1:0]    r_wr_data;
    logic                r_net_start;
    logic                r_net_bank;
    logic                r_disp_bank;
    logic                r_busy;
    logic [7:0]          r_drop_cnt;
    logic [7:0]          r_err_cnt;

    logic                w_hdr_en;
    logic                w_done;
    logic                w_swap;

    // Headers are only honoured in continuous mode or when single-shot is armed
    assign w_hdr_en = ~mode | r_armed;
    // A net_done with no inference running carries no information
    assign w_done   = net_done & r_busy;
    // The full bank can be handed over when the net is idle or finishing this cycle
    assign w_swap   = (r_state == S_FULL) & (~r_busy | w_done);

    // Frame FSM, RAM write port, bank handover and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_HUNT;
            r_addr      <= '0;
            r_idle      <= '0;
            r_armed     <= 1'b1;
            r_seen_hdr0 <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_wr_bank   <= 1'b0;
            r_net_start <= 1'b0;
            r_net_bank  <= 1'b1;
            r_disp_bank <= 1'b1;
            r_busy      <= 1'b0;
            r_drop_cnt  <= 8'd0;
            r_err_cnt   <= 8'd0;
        end else begin
            r_wr_en     <= 1'b0;
            r_net_start <= 1'b0;

            if (mode && arm) begin
                r_armed <= 1'b1;
            end

            if (w_done) begin
                r_busy      <= 1'b0;
                r_disp_bank <= r_net_bank;
            end

            case (r_state)
                S_HUNT: begin
                    if (in_valid && w_hdr_en && (in_data == HDR0)) begin
                        r_state <= S_HDR;
                    end
                end

                S_HDR: begin
                    if (in_valid) begin
                        if (in_data == HDR1) begin
                            r_state <= S_LOAD;
                            r_addr  <= '0;
                            r_idle  <= '0;
                        end else if (in_data != HDR0) begin
                            r_state <= S_HUNT;
                        end
                    end
                end

                S_LOAD: begin
                    if (in_valid) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_addr;
                        r_wr_data <= in_data[PIX_W-1:0];
                        r_idle    <= '0;
                        if (r_addr == LAST_ADDR) begin
                            r_addr      <= '0;
                            r_state     <= S_FULL;
                            r_seen_hdr0 <= 1'b0;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end else if (r_idle >= IDLE_LAST) begin
                        // Sender stalled mid-frame: drop the partial frame, keep the bank
                        r_state <= S_HUNT;
                        r_addr  <= '0;
                        r_idle  <= '0;
                        if (r_err_cnt != 8'hFF) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                    end else begin
                        r_idle <= r_idle + 24'd1;
                    end
                end

                S_FULL: begin
                    if (w_swap) begin
                        // Assigned after the w_done clear so busy stays set on back-to-back handover
                        r_net_bank  <= r_wr_bank;
                        r_wr_bank   <= ~r_wr_bank;
                        r_net_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_HUNT;
                        if (mode) begin
                            r_armed <= 1'b0;
                        end
                    end else if (in_valid) begin
                        // Frame held; every header pair seen now is a lost frame
                        if (r_seen_hdr0 && (in_data == HDR1) && (r_drop_cnt != 8'hFF)) begin
                            r_drop_cnt <= r_drop_cnt + 8'd1;
                        end
                        r_seen_hdr0 <= (in_data == HDR0);
                    end
                end

                default: r_state <= S_HUNT;
            endcase
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_bank   = r_wr_bank;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign net_start = r_net_start;
    assign net_bank  = r_net_bank;
    assign disp_bank = r_disp_bank;
    assign busy      = r_busy;
    assign drop_cnt  = r_drop_cnt;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_img_pingpong_loader.sv
// tb/tb_img_pingpong_loader.sv - directed self-checking bench for img_pingpong_loader
module tb_img_pingpong_loader;

    localparam int          PIX_W = 8;
    localparam int          IMG   = 784;
    localparam int          AW    = 10;
    localparam logic [23:0] TO    = 24'd200;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [7:0]      in_data;
    logic            mode;
    logic            arm;
    logic            wr_en;
    logic            wr_bank;
    logic [AW-1:0]   wr_addr;
    logic [PIX_W-1:0] wr_data;
    logic            net_start;
    logic            net_bank;
    logic            net_done;
    logic            disp_bank;
    logic            busy;
    logic [7:0]      drop_cnt;
    logic [7:0]      err_cnt;

    int checks   = 0;
    int failures = 0;
    int ns_count = 0;
    int ns0;
    int bad;

    typedef struct packed {
        logic          v;
        logic [7:0]    d;
        logic          en;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } vec_t;

    vec_t vecs [11];

    always #5 clk = ~clk;

    img_pingpong_loader #(
        .PIX_W(PIX_W), .IMG_PIXELS(IMG), .ADDR_W(AW),
        .HDR0(8'h55), .HDR1(8'hAA), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .mode(mode), .arm(arm), .wr_en(wr_en), .wr_bank(wr_bank),
        .wr_addr(wr_addr), .wr_data(wr_data), .net_start(net_start),
        .net_bank(net_bank), .net_done(net_done), .disp_bank(disp_bank),
        .busy(busy), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
    );

    always @(negedge clk) begin
        if (net_start) ns_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_wr_en"}, 32'(wr_en), 0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 0);
        check({tag, "_wr_data"}, 32'(wr_data), 0);
        check({tag, "_wr_bank"}, 32'(wr_bank), 0);
        check({tag, "_net_start"}, 32'(net_start), 0);
        check({tag, "_net_bank"}, 32'(net_bank), 1);
        check({tag, "_disp_bank"}, 32'(disp_bank), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_drop_cnt"}, 32'(drop_cnt), 0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; net_done = 1'b0; arm = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_hdr(output int nbad);
        nbad = 0;
        drive_byte(8'h55);
        if (wr_en !== 1'b0) nbad++;
        drive_byte(8'hAA);
        if (wr_en !== 1'b0) nbad++;
    endtask

    task automatic send_pixels(input int n, input int start, input logic bank,
                               input bit exp_wr, output int nbad);
        nbad = 0;
        for (int i = 0; i < n; i++) begin
            drive_byte(8'((start + i) % 256));
            if (exp_wr) begin
                if (!(wr_en === 1'b1 && int'(wr_addr) == start + i &&
                      int'(wr_data) == (start + i) % 256 && wr_bank === bank))
                    nbad++;
            end else if (wr_en !== 1'b0) begin
                nbad++;
            end
        end
    endtask

    task automatic send_frame(input logic bank, input bit exp_wr, input string name);
        int b1;
        int b2;
        send_hdr(b1);
        send_pixels(IMG, 0, bank, exp_wr, b2);
        check(name, b1 + b2, 0);
    endtask

    task automatic pulse_done();
        net_done = 1'b1;
        tick();
        net_done = 1'b0;
    endtask

    initial begin
        vecs[0]  = {1'b1, 8'h12, 1'b0, 10'd0, 8'h00};
        vecs[1]  = {1'b1, 8'hAA, 1'b0, 10'd0, 8'h00};
        vecs[2]  = {1'b0, 8'h00, 1'b0, 10'd0, 8'h00};
        vecs[3]  = {1'b1, 8'h55, 1'b0, 10'd0, 8'h00};
        vecs[4]  = {1'b1, 8'h55, 1'b0, 10'd0, 8'h00};
        vecs[5]  = {1'b1, 8'hAA, 1'b0, 10'd0, 8'h00};
        vecs[6]  = {1'b1, 8'h00, 1'b1, 10'd0, 8'h00};
        vecs[7]  = {1'b0, 8'h00, 1'b0, 10'd0, 8'h00};
        vecs[8]  = {1'b1, 8'h01, 1'b1, 10'd1, 8'h01};
        vecs[9]  = {1'b1, 8'h02, 1'b1, 10'd2, 8'h02};
        vecs[10] = {1'b1, 8'h03, 1'b1, 10'd3, 8'h03};

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; mode = 1'b0;
        arm = 1'b0; net_done = 1'b0;
        do_reset();
        check_reset("rst0");

        // Header hunting and the start of a frame on bank 0
        for (int i = 0; i < 11; i++) begin
            in_valid = vecs[i].v;
            in_data  = vecs[i].d;
            tick();
            in_valid = 1'b0;
            check($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].en));
            check($sformatf("vec%0d_wr_addr", i), 32'(wr_addr), 32'(vecs[i].addr));
            check($sformatf("vec%0d_wr_data", i), 32'(wr_data), 32'(vecs[i].data));
        end
        send_pixels(IMG - 4, 4, 1'b0, 1'b1, bad);
        check("f1_pixels", bad, 0);
        check("f1_last_addr", 32'(wr_addr), IMG - 1);
        check("f1_start_early", 32'(net_start), 0);
        tick();
        check("f1_net_start", 32'(net_start), 1);
        check("f1_net_bank", 32'(net_bank), 0);
        check("f1_wr_bank", 32'(wr_bank), 1);
        check("f1_busy", 32'(busy), 1);
        tick();
        check("f1_start_pulse", 32'(net_start), 0);
        pulse_done();
        check("f1_done_busy", 32'(busy), 0);
        check("f1_done_disp", 32'(disp_bank), 0);
        tick();
        ns0 = ns_count;
        pulse_done();
        tick();
        check("stray_done_disp", 32'(disp_bank), 0);
        check("stray_done_busy", 32'(busy), 0);
        check("stray_done_start", ns_count, ns0);

        // Hold a full frame while the net is busy, count a drop, hand over on net_done
        do_reset();
        send_frame(1'b0, 1'b1, "hold_a_writes");
        tick();
        check("hold_a_start", 32'(net_start), 1);
        tick();
        tick();
        ns0 = ns_count;
        send_frame(1'b1, 1'b1, "hold_b_writes");
        tick();
        tick();
        check("hold_b_no_start", ns_count, ns0);
        check("hold_b_wr_bank", 32'(wr_bank), 1);
        check("hold_banks_differ", 32'(net_bank == wr_bank), 0);
        send_hdr(bad);
        check("hold_c_hdr_no_wr", bad, 0);
        send_pixels(10, 0, 1'b1, 1'b0, bad);
        check("hold_c_no_wr", bad, 0);
        check("hold_drop_cnt", 32'(drop_cnt), 1);
        net_done = 1'b1;
        tick();
        net_done = 1'b0;
        check("handover_start", 32'(net_start), 1);
        check("handover_net_bank", 32'(net_bank), 1);
        check("handover_disp_bank", 32'(disp_bank), 0);
        check("handover_busy", 32'(busy), 1);
        check("handover_wr_bank", 32'(wr_bank), 0);

        // Inter-byte timeout: a gap one short survives, a full gap aborts
        do_reset();
        send_hdr(bad);
        send_pixels(50, 0, 1'b0, 1'b1, bad);
        repeat (int'(TO) - 1) tick();
        send_pixels(50, 50, 1'b0, 1'b1, bad);
        check("to_short_gap_continues", bad, 0);
        repeat (int'(TO) - 1) tick();
        check("to_err_before", 32'(err_cnt), 0);
        tick();
        check("to_err_after", 32'(err_cnt), 1);
        check("to_wr_bank", 32'(wr_bank), 0);
        check("to_busy", 32'(busy), 0);
        send_frame(1'b0, 1'b1, "to_refill_writes");
        tick();
        check("to_refill_start", 32'(net_start), 1);
        check("to_refill_net_bank", 32'(net_bank), 0);

        // Single-shot mode needs arm between frames
        do_reset();
        mode = 1'b1;
        send_frame(1'b0, 1'b1, "ss_f1_writes");
        tick();
        check("ss_f1_start", 32'(net_start), 1);
        tick();
        pulse_done();
        ns0 = ns_count;
        send_frame(1'b1, 1'b0, "ss_f2_ignored");
        tick();
        tick();
        check("ss_f2_no_start", ns_count, ns0);
        check("ss_f2_no_drop", 32'(drop_cnt), 0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        send_frame(1'b1, 1'b1, "ss_f3_writes");
        tick();
        check("ss_f3_start", 32'(net_start), 1);
        check("ss_f3_net_bank", 32'(net_bank), 1);
        mode = 1'b0;

        // Reset in the middle of a frame
        do_reset();
        send_frame(1'b0, 1'b1, "pre_mid_writes");
        tick();
        tick();
        send_hdr(bad);
        send_pixels(400, 0, 1'b1, 1'b1, bad);
        check("mid_pixels", bad, 0);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'(400 % 256);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check_reset("mid_rst");
        ns0 = ns_count;
        send_pixels(10, 401, 1'b0, 1'b0, bad);
        tick();
        check("mid_after_no_wr", bad, 0);
        check("mid_after_no_start", ns_count, ns0);
        send_frame(1'b0, 1'b1, "mid_new_frame");
        tick();
        check("mid_new_start", 32'(net_start), 1);
        check("mid_new_net_bank", 32'(net_bank), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
